// File: rtl/spi_flash_responder_pkg.sv
// Shared opcodes, FSM state encoding and helpers for the SPI flash responder.
package spi_flash_responder_pkg;

  localparam int unsigned SYNC_STAGES = 2;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_RDID = 8'h9F;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StCmd    = 3'd1,
    StAddr   = 3'd2,
    StDataRd = 3'd3,
    StDataSr = 3'd4,
    StDataId = 3'd5,
    StIgnore = 3'd6
  } state_e;

  // Byte idx of the 3-byte JEDEC ID, MSB first.
  function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = id[23:16];
      2'd1:    b = id[15:8];
      default: b = id[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronizes the host CS#/SCLK/IO0 pins into the main clock domain and
// produces single-cycle edge pulses for CS# and SCLK.
module spi_pin_sync
  import spi_flash_responder_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_cs_n,
  input  logic i_sclk,
  input  logic i_io0,
  output logic o_io0,
  output logic o_cs_fall,
  output logic o_cs_rise,
  output logic o_sclk_rise,
  output logic o_sclk_fall
);

  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_io0_sync;
  logic                   r_cs_hist;
  logic                   r_sclk_hist;
  logic                   w_cs;
  logic                   w_sclk;

  // CS# resets to its idle (high) level so release of reset never fakes a select.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cs_sync   <= '1;
      r_sclk_sync <= '0;
      r_io0_sync  <= '0;
      r_cs_hist   <= 1'b1;
      r_sclk_hist <= 1'b0;
    end else begin
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs_n};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
      r_io0_sync  <= {r_io0_sync[SYNC_STAGES-2:0], i_io0};
      r_cs_hist   <= w_cs;
      r_sclk_hist <= w_sclk;
    end
  end

  assign w_cs        = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign o_io0       = r_io0_sync[SYNC_STAGES-1];
  assign o_cs_fall   = r_cs_hist & ~w_cs;
  assign o_cs_rise   = ~r_cs_hist & w_cs;
  assign o_sclk_rise = ~r_sclk_hist & w_sclk;
  assign o_sclk_fall = r_sclk_hist & ~w_sclk;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI NOR-flash responder (mode 0, single I/O): decodes READ/RDSR/RDID and
// streams bytes from a synchronous byte memory onto IO1.
module spi_flash_responder
  import spi_flash_responder_pkg::*;
#(
  parameter logic [23:0] JEDEC_ID   = 24'hEF4018,
  parameter logic [7:0]  STATUS_VAL = 8'h00
) (
  input  logic        CLK_25M_CKMNG_MAIN_PLD,
  input  logic        PWRGD_P1V2_MAX10_AUX_PLD_R,
  input  logic        spi_cs_n,
  input  logic        spi_clk,
  input  logic        spi_io0,
  output logic        spi_io1_out,
  output logic        spi_io1_oe,
  output logic [23:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic [15:0] bytes_sent,
  output logic        done
);

  logic w_io0, w_cs_fall, w_cs_rise, w_sclk_rise, w_sclk_fall;

  spi_pin_sync u_pin_sync (
    .i_clk       (CLK_25M_CKMNG_MAIN_PLD),
    .i_rst_n     (PWRGD_P1V2_MAX10_AUX_PLD_R),
    .i_cs_n      (spi_cs_n),
    .i_sclk      (spi_clk),
    .i_io0       (spi_io0),
    .o_io0       (w_io0),
    .o_cs_fall   (w_cs_fall),
    .o_cs_rise   (w_cs_rise),
    .o_sclk_rise (w_sclk_rise),
    .o_sclk_fall (w_sclk_fall)
  );

  state_e      r_state,      w_state_nxt;
  logic [4:0]  r_bit_cnt,    w_bit_cnt_nxt;
  logic [23:0] r_rx_shift,   w_rx_shift_nxt;
  logic [7:0]  r_tx_shift,   w_tx_shift_nxt;
  logic [2:0]  r_tx_bit,     w_tx_bit_nxt;
  logic [7:0]  r_next_byte,  w_next_byte_nxt;
  logic [1:0]  r_id_idx,     w_id_idx_nxt;
  logic        r_rd_dly,     w_rd_dly_nxt;
  logic        r_io1_out,    w_io1_out_nxt;
  logic        r_io1_oe,     w_io1_oe_nxt;
  logic [23:0] r_mem_addr,   w_mem_addr_nxt;
  logic        r_mem_rd,     w_mem_rd_nxt;
  logic        r_busy,       w_busy_nxt;
  logic [15:0] r_bytes_sent, w_bytes_sent_nxt;
  logic        r_done,       w_done_nxt;
  logic [23:0] w_rx_bits;

  assign w_rx_bits = {r_rx_shift[22:0], w_io0};

  always_ff @(posedge CLK_25M_CKMNG_MAIN_PLD or negedge PWRGD_P1V2_MAX10_AUX_PLD_R) begin
    if (!PWRGD_P1V2_MAX10_AUX_PLD_R) begin
      r_state      <= StIdle;
      r_bit_cnt    <= '0;
      r_rx_shift   <= '0;
      r_tx_shift   <= '0;
      r_tx_bit     <= '0;
      r_next_byte  <= '0;
      r_id_idx     <= '0;
      r_rd_dly     <= 1'b0;
      r_io1_out    <= 1'b0;
      r_io1_oe     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_rd     <= 1'b0;
      r_busy       <= 1'b0;
      r_bytes_sent <= '0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_rx_shift   <= w_rx_shift_nxt;
      r_tx_shift   <= w_tx_shift_nxt;
      r_tx_bit     <= w_tx_bit_nxt;
      r_next_byte  <= w_next_byte_nxt;
      r_id_idx     <= w_id_idx_nxt;
      r_rd_dly     <= w_rd_dly_nxt;
      r_io1_out    <= w_io1_out_nxt;
      r_io1_oe     <= w_io1_oe_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_rd     <= w_mem_rd_nxt;
      r_busy       <= w_busy_nxt;
      r_bytes_sent <= w_bytes_sent_nxt;
      r_done       <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_rx_shift_nxt   = r_rx_shift;
    w_tx_shift_nxt   = r_tx_shift;
    w_tx_bit_nxt     = r_tx_bit;
    w_next_byte_nxt  = r_next_byte;
    w_id_idx_nxt     = r_id_idx;
    // Memory data is valid one clock after the strobe is sampled, i.e. when this is set.
    w_rd_dly_nxt     = r_mem_rd;
    w_io1_out_nxt    = r_io1_out;
    w_io1_oe_nxt     = r_io1_oe;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_rd_nxt     = 1'b0;
    w_busy_nxt       = r_busy;
    w_bytes_sent_nxt = r_bytes_sent;
    w_done_nxt       = 1'b0;

    if (w_cs_rise) begin
      w_state_nxt  = StIdle;
      w_io1_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
      w_done_nxt   = (r_state == StDataRd);
    end else if (w_cs_fall) begin
      w_state_nxt   = StCmd;
      w_bit_cnt_nxt = '0;
      w_busy_nxt    = 1'b1;
      w_io1_oe_nxt  = 1'b0;
    end else begin
      unique case (r_state)
        StCmd: begin
          if (w_sclk_rise) begin
            w_rx_shift_nxt = w_rx_bits;
            w_bit_cnt_nxt  = r_bit_cnt + 5'd1;
            if (r_bit_cnt == 5'd7) begin
              w_bit_cnt_nxt = '0;
              w_tx_bit_nxt  = '0;
              case (w_rx_bits[7:0])
                OP_READ: begin
                  w_state_nxt      = StAddr;
                  w_bytes_sent_nxt = '0;
                end
                OP_RDSR: begin
                  w_state_nxt    = StDataSr;
                  w_tx_shift_nxt = STATUS_VAL;
                end
                OP_RDID: begin
                  w_state_nxt    = StDataId;
                  w_tx_shift_nxt = id_byte(JEDEC_ID, 2'd0);
                  w_id_idx_nxt   = 2'd1;
                end
                default: w_state_nxt = StIgnore;
              endcase
            end
          end
        end

        StAddr: begin
          if (w_sclk_rise && (r_bit_cnt != 5'd24)) begin
            w_rx_shift_nxt = w_rx_bits;
            w_bit_cnt_nxt  = r_bit_cnt + 5'd1;
            if (r_bit_cnt == 5'd23) begin
              w_mem_addr_nxt = w_rx_bits;
              w_mem_rd_nxt   = 1'b1;
            end
          end
          if (r_rd_dly && (r_bit_cnt == 5'd24)) begin
            w_tx_shift_nxt = mem_rdata;
            w_state_nxt    = StDataRd;
          end
        end

        StDataRd, StDataSr, StDataId: begin
          if ((r_state == StDataRd) && r_rd_dly) w_next_byte_nxt = mem_rdata;
          if (w_sclk_fall) begin
            w_io1_out_nxt  = r_tx_shift[7];
            w_io1_oe_nxt   = 1'b1;
            w_tx_shift_nxt = {r_tx_shift[6:0], 1'b0};
            w_tx_bit_nxt   = r_tx_bit + 3'd1;
            // Prefetch the following byte as soon as the current one starts shifting.
            if ((r_state == StDataRd) && (r_tx_bit == 3'd0)) begin
              w_mem_addr_nxt = r_mem_addr + 24'd1;
              w_mem_rd_nxt   = 1'b1;
            end
            if (r_tx_bit == 3'd7) begin
              if (r_state == StDataRd) begin
                w_tx_shift_nxt   = r_next_byte;
                w_bytes_sent_nxt = r_bytes_sent + 16'd1;
              end else if (r_state == StDataSr) begin
                w_tx_shift_nxt = STATUS_VAL;
              end else begin
                w_tx_shift_nxt = id_byte(JEDEC_ID, r_id_idx);
                w_id_idx_nxt   = (r_id_idx == 2'd2) ? 2'd0 : r_id_idx + 2'd1;
              end
            end
          end
        end

        default: ;
      endcase
    end
  end

  assign spi_io1_out = r_io1_out;
  assign spi_io1_oe  = r_io1_oe;
  assign mem_addr    = r_mem_addr;
  assign mem_rd      = r_mem_rd;
  assign busy        = r_busy;
  assign bytes_sent  = r_bytes_sent;
  assign done        = r_done;

endmodule
